tt_um_inv_bank_gen2: RTL
========================

Name: tt_um_inv_bank_gen2

Overview:
- Second-generation input-conditioning bank for the TinyTapeout tile. CH channels, each: synchroniser, optional debounce, per-channel runtime-selectable output function (pass, invert, toggle, pulse).
- Mode is written through a strobed config port on uio_in.
- ui_in bits above CH pass straight through to uo_out.

Parameters:
- CH, 4, number of conditioned channels; legal range 1..8.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..3.
- DEBOUNCE, 0, consecutive stable cycles required before the filtered value changes; 0 bypasses the filter; legal range 0..255.

Ports:
- clk  in  1  tile clock.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  tile enable; low freezes all state.
- ui_in  in  8  [CH-1:0] channel inputs; [7:CH] pass-through.
- uo_out  out  8  [CH-1:0] registered channel outputs; [7:CH] = ui_in[7:CH], combinational.
- uio_in  in  8  config bus: [2:0] channel index, [4:3] mode, [5] clr_state, [7] cfg_wr.
- uio_out  out  8  [6] cfg_ack; all other bits 0.
- uio_oe  out  8  constant 8'b0100_0000.

Behaviour:
- Reset is sampled on rising clk edges only. While rst_n=0: all mode registers = INVERT (2'b01); sync flops, filtered values, toggle state, debounce counters, cfg_wr sync and cfg_ack all 0; uo_out[CH-1:0] = 0.
- Modes:
  - 00 PASS: out = filt.
  - 01 INVERT: out = ~filt.
  - 10 TOGGLE: state flips on each filt 0->1; out = state.
  - 11 PULSE: out = 1 for exactly one cycle on filt 0->1.
- Edge detection uses a previous-filt register per channel.
- Latency with DEBOUNCE=0: ui_in change captured at edge 1 appears on uo_out after edge SYNC_STAGES+1 (3 edges by default).
- Debounce, DEBOUNCE=N>0:
  - Per-channel counter, width clog2(N+1). Counter increments while sync != filt and clears when they are equal.
  - When the counter would reach N, filt <= sync and the counter clears. This adds exactly N cycles of latency.
  - A glitch shorter than N cycles never reaches filt.
- First cycle after reset release: uo_out updates from filt=0 (INVERT channels go to 1 after the first edge). No spurious TOGGLE/PULSE edge, because prev is 0.
- Config:
  - uio_in[7] passes through the same SYNC_STAGES synchroniser. A synchronised 0->1 edge is a write.
  - On a write, index and mode are sampled from the same cycle in which the synchronised edge is detected. The host must hold them stable from cfg_wr rise until cfg_ack.
  - Index < CH: mode[index] updated; cfg_ack = 1 for exactly the next cycle.
  - Index >= CH: write ignored; no ack.
  - A new mode takes effect on the output computed in the cycle after the write. Toggle state is not cleared by a mode change.
- clr_state (uio_in[5], synchronised, level): while 1, all toggle states are held at 0. It has no effect on mode registers.
- ena=0: every register holds its value (including debounce counters and the cfg edge detector); uo_out[CH-1:0] holds. Pass-through bits are still live.
- Simultaneous events:
  - Write and input edge in the same cycle: the edge is processed under the old mode.
  - rst_n=0 overrides ena and all writes.
  - Reset mid-debounce discards the pending count.
- CH=8: no pass-through bits.

Decomposition:
- Package inv_bank_pkg: mode_e typedef (MODE_PASS, MODE_INV, MODE_TOGGLE, MODE_PULSE), mode width constant 2, reset mode constant MODE_INV, config bit-position constants.
- Sub-module inv_bank_chan: one channel = synchroniser + debounce + edge detect + mode mux + output flop. Instantiated CH times via generate.
- Top level: config synchroniser, write decode, ack, pass-through.

Test Plan:
- Reset defaults: CH=4. Hold rst_n=0 for 3 cycles with ui_in=8'hA0 -> uo_out=8'hA0. Release -> uo_out=8'hAF after 3 edges (INVERT of 0).
- Pass/invert latency: ui_in[0] 0->1 at edge k -> uo_out[0] falls after edge k+3. Write channel 1 mode PASS (uio_in=8'h81 then 8'h01) -> cfg_ack one cycle; uo_out[1] then follows ui_in[1].
- Toggle/pulse: channel 2 TOGGLE, three rising edges on ui_in[2] -> uo_out[2] sequence 1,0,1. Channel 3 PULSE -> single-cycle high per edge. Assert clr_state -> toggle state 0.
- Debounce: DEBOUNCE=4. 3-cycle glitch on ui_in[0] -> no output change. 6-cycle pulse -> output changes 4 cycles later than with DEBOUNCE=0.
- Bad index / ena: write index 5 with CH=4 -> no ack, modes unchanged. ena=0 during an input edge -> uo_out[CH-1:0] frozen; ena=1 -> change appears with normal latency.
- Reset mid-operation: assert rst_n=0 during a TOGGLE run and during a pending write -> all modes back to INVERT, toggle state 0, no ack after release.

Source files
------------

// File: rtl/inv_bank_pkg.sv
// Shared types and constants for the input-conditioning bank: channel modes
// and bit positions on the config bus.
package inv_bank_pkg;

  localparam int unsigned MODE_W       = 2;
  localparam int unsigned CFG_IDX_LSB  = 0;
  localparam int unsigned CFG_IDX_W    = 3;
  localparam int unsigned CFG_MODE_LSB = 3;
  localparam int unsigned CFG_CLR_BIT  = 5;
  localparam int unsigned CFG_ACK_BIT  = 6;
  localparam int unsigned CFG_WR_BIT   = 7;
  localparam logic [7:0]  UIO_OE       = 8'b0100_0000;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_e;

  localparam mode_e MODE_RST = MODE_INV;

endpackage

// File: rtl/inv_bank_chan.sv
// One conditioned channel: synchroniser, optional debounce filter, rising-edge
// detect and a registered mode-selected output.
module inv_bank_chan
  import inv_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  din,
  input  mode_e mode,
  input  logic  clr,
  output logic  dout
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_last;
  logic                   filt;
  logic                   prev;
  logic                   tog;
  logic                   rise;
  logic                   tog_next;
  logic                   out_next;

  assign sync_last = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else if (ena) begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  if (DEBOUNCE == 0) begin : g_nodb
    assign filt = sync_last;
  end else begin : g_db
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    logic [CW-1:0] cnt;
    logic          filt_q;

    // Count cycles of disagreement; adopt the new level once it has held DEBOUNCE cycles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (ena) begin
        if (sync_last == filt_q) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
          filt_q <= sync_last;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign filt = filt_q;
  end

  always_comb begin
    rise     = filt & ~prev;
    tog_next = clr ? 1'b0 : (tog ^ rise);
    out_next = 1'b0;
    case (mode)
      MODE_PASS:   out_next = filt;
      MODE_INV:    out_next = ~filt;
      MODE_TOGGLE: out_next = tog_next;
      MODE_PULSE:  out_next = rise;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
      tog  <= 1'b0;
      dout <= 1'b0;
    end else if (ena) begin
      prev <= filt;
      tog  <= tog_next;
      dout <= out_next;
    end
  end

endmodule

// File: rtl/tt_um_inv_bank_gen2.sv
// Input-conditioning bank top: config write synchroniser and decode, per-channel
// mode registers, channel array and pass-through of the unconditioned inputs.
module tt_um_inv_bank_gen2
  import inv_bank_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   wr_prev;
  logic                   cfg_ack;
  mode_e                  mode_q [CH];
  logic [CH-1:0]          chan_out;

  logic                   wr_edge_c;
  logic                   wr_en_c;
  logic [CFG_IDX_W-1:0]   idx_c;
  mode_e                  wr_mode_c;
  logic                   unused_bits;

  assign unused_bits = uio_in[4'(CFG_ACK_BIT)];

  // Index and mode are taken unsynchronised; the host holds them until ack.
  always_comb begin
    idx_c     = uio_in[CFG_IDX_LSB +: CFG_IDX_W];
    wr_mode_c = mode_e'(uio_in[CFG_MODE_LSB +: MODE_W]);
    wr_edge_c = wr_sync[SYNC_STAGES-1] & ~wr_prev;
    wr_en_c   = wr_edge_c && (32'(idx_c) < CH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sync  <= '0;
      clr_sync <= '0;
      wr_prev  <= 1'b0;
      cfg_ack  <= 1'b0;
      for (int i = 0; i < int'(CH); i++) mode_q[i] <= MODE_RST;
    end else if (ena) begin
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], uio_in[CFG_WR_BIT]};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], uio_in[CFG_CLR_BIT]};
      wr_prev  <= wr_sync[SYNC_STAGES-1];
      cfg_ack  <= wr_en_c;
      for (int i = 0; i < int'(CH); i++) begin
        if (wr_en_c && idx_c == CFG_IDX_W'(i)) mode_q[i] <= wr_mode_c;
      end
    end
  end

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    inv_bank_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .din  (ui_in[i]),
      .mode (mode_q[i]),
      .clr  (clr_sync[SYNC_STAGES-1]),
      .dout (chan_out[i])
    );
  end

  if (CH < 8) begin : g_pt
    assign uo_out = {ui_in[7:CH], chan_out};
  end else begin : g_nopt
    assign uo_out = chan_out;
  end

  assign uio_out = 8'(cfg_ack) << CFG_ACK_BIT;
  assign uio_oe  = UIO_OE;

endmodule
